// File: rtl/i2c_eeprom_slave_ctrl.sv
// I2C slave front end for a 256-byte EEPROM-style memory: device select,
// word-address pointer, byte writes with auto-increment and sequential reads.
module i2c_eeprom_slave_ctrl #(
  parameter logic [3:0]  DEV_TYPE = 4'b1000,
  parameter int unsigned MIN_LOW  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  input  logic       a2,
  input  logic       a1,
  input  logic       a0,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV_ADDR  = 4'd1,
    DEV_ACK   = 4'd2,
    WORD_ADDR = 4'd3,
    WA_ACK    = 4'd4,
    WR_DATA   = 4'd5,
    WD_ACK    = 4'd6,
    RD_LOAD   = 4'd7,
    RD_DATA   = 4'd8,
    RD_ACK    = 4'd9,
    WAIT_STOP = 4'd10
  } state_t;

  // After reset the synchronizers hold 1 and must flush before edges are trusted.
  localparam int unsigned SETTLE = (MIN_LOW > 3) ? MIN_LOW : 3;
  localparam int unsigned SW     = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);

  logic          scl_meta_r, scl_sync_r, scl_d_r;
  logic          sda_meta_r, sda_sync_r, sda_d_r;
  logic [SW-1:0] settle_r;

  state_t     state_r, state_nxt_s;
  logic       sda_oe_r, sda_oe_nxt_s;
  logic [7:0] mem_addr_r, mem_addr_nxt_s;
  logic [7:0] mem_wdata_r, mem_wdata_nxt_s;
  logic       mem_we_r, mem_we_nxt_s;
  logic       mem_re_r, mem_re_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic       rw_r, rw_nxt_s;

  logic       bus_ok_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic       last_bit_s, addr_match_s;
  logic [7:0] rx_byte_s;

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_d_r    <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_d_r    <= 1'b1;
      settle_r   <= '0;
    end else begin
      scl_meta_r <= scl;
      scl_sync_r <= scl_meta_r;
      scl_d_r    <= scl_sync_r;
      sda_meta_r <= sda;
      sda_sync_r <= sda_meta_r;
      sda_d_r    <= sda_sync_r;
      if (settle_r != SETTLE_MAX) settle_r <= settle_r + SW'(1);
      else                        settle_r <= settle_r;
    end
  end

  assign bus_ok_s     = (settle_r == SETTLE_MAX);
  assign scl_rise_s   = bus_ok_s & scl_sync_r & ~scl_d_r;
  assign scl_fall_s   = bus_ok_s & ~scl_sync_r & scl_d_r;
  assign start_s      = bus_ok_s & scl_sync_r & scl_d_r & sda_d_r & ~sda_sync_r;
  assign stop_s       = bus_ok_s & scl_sync_r & scl_d_r & ~sda_d_r & sda_sync_r;
  assign rx_byte_s    = {shift_r[6:0], sda_sync_r};
  assign last_bit_s   = (bit_cnt_r == 3'd7);
  assign addr_match_s = (rx_byte_s[7:1] == {DEV_TYPE, a2, a1, a0});

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; START outranks STOP, both outrank everything else.
  always_comb begin
    state_nxt_s = state_r;
    if (start_s) begin
      state_nxt_s = DEV_ADDR;
    end else if (stop_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        DEV_ADDR:  if (scl_rise_s && last_bit_s) state_nxt_s = addr_match_s ? DEV_ACK : WAIT_STOP;
                   else state_nxt_s = state_r;
        DEV_ACK:   if (scl_rise_s && sda_oe_r && rw_r) state_nxt_s = RD_LOAD;
                   else if (scl_fall_s && sda_oe_r && !rw_r) state_nxt_s = WORD_ADDR;
                   else state_nxt_s = state_r;
        WORD_ADDR: if (scl_rise_s && last_bit_s) state_nxt_s = WA_ACK;
                   else state_nxt_s = state_r;
        WA_ACK:    if (scl_fall_s && sda_oe_r) state_nxt_s = WR_DATA;
                   else state_nxt_s = state_r;
        WR_DATA:   if (scl_rise_s && last_bit_s) state_nxt_s = WD_ACK;
                   else state_nxt_s = state_r;
        WD_ACK:    if (scl_fall_s && sda_oe_r) state_nxt_s = WR_DATA;
                   else state_nxt_s = state_r;
        RD_LOAD:   if (bit_cnt_r == 3'd2) state_nxt_s = RD_DATA;
                   else state_nxt_s = state_r;
        RD_DATA:   if (scl_rise_s && last_bit_s) state_nxt_s = RD_ACK;
                   else state_nxt_s = state_r;
        RD_ACK:    if (scl_rise_s) state_nxt_s = sda_sync_r ? WAIT_STOP : RD_LOAD;
                   else state_nxt_s = state_r;
        default:   state_nxt_s = state_r;
      endcase
    end
  end

  // Output and datapath next values; ACK phases toggle sda_oe on successive scl falls.
  always_comb begin
    sda_oe_nxt_s    = sda_oe_r;
    mem_addr_nxt_s  = mem_we_r ? (mem_addr_r + 8'd1) : mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    mem_we_nxt_s    = 1'b0;
    mem_re_nxt_s    = 1'b0;
    bit_cnt_nxt_s   = bit_cnt_r;
    shift_nxt_s     = shift_r;
    rw_nxt_s        = rw_r;
    busy_nxt_s      = (state_nxt_s != IDLE);
    if (start_s || stop_s) begin
      sda_oe_nxt_s  = 1'b0;
      bit_cnt_nxt_s = 3'd0;
    end else begin
      case (state_r)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (scl_rise_s) begin
            shift_nxt_s   = rx_byte_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            if (last_bit_s) begin
              case (state_r)
                DEV_ADDR:  rw_nxt_s       = sda_sync_r;
                WORD_ADDR: mem_addr_nxt_s = rx_byte_s;
                default: begin
                  mem_we_nxt_s    = 1'b1;
                  mem_wdata_nxt_s = rx_byte_s;
                end
              endcase
            end else begin
              mem_we_nxt_s = 1'b0;
            end
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end
        DEV_ACK, WA_ACK, WD_ACK: begin
          if (scl_fall_s) sda_oe_nxt_s = ~sda_oe_r;
          else            sda_oe_nxt_s = sda_oe_r;
        end
        // bit_cnt doubles as the strobe/capture sequencer while loading.
        RD_LOAD: begin
          case (bit_cnt_r)
            3'd0: begin
              mem_re_nxt_s  = 1'b1;
              bit_cnt_nxt_s = 3'd1;
            end
            3'd1: bit_cnt_nxt_s = 3'd2;
            3'd2: begin
              shift_nxt_s   = mem_rdata;
              bit_cnt_nxt_s = 3'd0;
            end
            default: bit_cnt_nxt_s = 3'd0;
          endcase
        end
        RD_DATA: begin
          if (scl_fall_s) begin
            sda_oe_nxt_s = ~shift_r[7];
            shift_nxt_s  = {shift_r[6:0], 1'b0};
          end else if (scl_rise_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        RD_ACK: begin
          if (scl_fall_s) sda_oe_nxt_s = 1'b0;
          else if (scl_rise_s && !sda_sync_r) mem_addr_nxt_s = mem_addr_r + 8'd1;
          else sda_oe_nxt_s = sda_oe_r;
        end
        default: sda_oe_nxt_s = 1'b0;
      endcase
    end
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sda_oe_r    <= 1'b0;
      mem_addr_r  <= 8'd0;
      mem_wdata_r <= 8'd0;
      mem_we_r    <= 1'b0;
      mem_re_r    <= 1'b0;
      busy_r      <= 1'b0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      rw_r        <= 1'b0;
    end else begin
      sda_oe_r    <= sda_oe_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_re_r    <= mem_re_nxt_s;
      busy_r      <= busy_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      rw_r        <= rw_nxt_s;
    end
  end

  assign sda_oe    = sda_oe_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign mem_re    = mem_re_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_eeprom_slave_ctrl.sv
// Directed bench: an I2C master model on an open-drain sda line and a
// synchronous memory model whose unwritten bytes read as addr ^ 8'hA5.
module tb_i2c_eeprom_slave_ctrl;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n, scl_m, sda_m, sda_oe, a2, a1, a0, mem_we, mem_re, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       sda_pad;
  int         checks = 0, errors = 0;

  bit [7:0]    mem [256];
  bit          vld [256];
  logic [15:0] we_log [$];
  logic [7:0]  re_log [$];
  bit          we_prev;
  int          we_long_cnt = 0, oe_cnt = 0;

  assign sda_pad = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_eeprom_slave_ctrl dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda_pad), .sda_oe(sda_oe),
    .a2(a2), .a1(a1), .a0(a0), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(negedge clk) begin
    if (mem_re === 1'b1) begin
      mem_rdata <= vld[mem_addr] ? mem[mem_addr] : (mem_addr ^ 8'hA5);
      re_log.push_back(mem_addr);
    end
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      vld[mem_addr] <= 1'b1;
      we_log.push_back({mem_addr, mem_wdata});
    end
    if (mem_we === 1'b1 && we_prev) we_long_cnt <= we_long_cnt + 1;
    we_prev <= (mem_we === 1'b1);
    if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
  end

  task automatic q_wait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic clock_bit(input logic b);
    sda_m = b; q_wait();
    scl_m = 1'b1; q_wait(); q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic get_ack(output logic ack);
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    ack = ~sda_pad; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) clock_bit(b[i]);
    get_ack(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q_wait();
      scl_m = 1'b1; q_wait();
      b = {b[6:0], sda_pad}; q_wait();
      scl_m = 1'b0;
    end
    q_wait();
    clock_bit(nack);
    sda_m = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; {a2, a1, a0} = 3'b101;
    @(posedge clk); @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr got %h want 00", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata got %h want 00", mem_wdata); end
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL rst_strobes got we=%b re=%b want 0 0", mem_we, mem_re); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic ack; int w0, r0, l0;
    logic [7:0] seq [4] = '{8'h8A, 8'h10, 8'h5A, 8'hC3};
    w0 = we_log.size(); r0 = re_log.size(); l0 = we_long_cnt;
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i], ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_ack[%0d] got %b want 1", i, ack); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", busy); end
    i2c_stop(); q_wait();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_idle got %b want 0", busy); end
    checks++;
    if (we_log.size() - w0 != 2) begin errors++; $display("FAIL write_we_count got %0d want 2", we_log.size() - w0); end
    else begin
      checks++; if (we_log[w0] !== 16'h105A) begin errors++; $display("FAIL write_we0 got %h want 105a", we_log[w0]); end
      checks++; if (we_log[w0+1] !== 16'h11C3) begin errors++; $display("FAIL write_we1 got %h want 11c3", we_log[w0+1]); end
    end
    checks++; if (mem_addr !== 8'h12) begin errors++; $display("FAIL write_final_addr got %h want 12", mem_addr); end
    checks++; if (re_log.size() != r0 || we_long_cnt != l0) begin errors++; $display("FAIL write_strobes got re=%0d long=%0d want 0 0", re_log.size() - r0, we_long_cnt - l0); end
  endtask

  task automatic test_read();
    logic ack; logic [7:0] d0, d1; int w0, r0;
    logic [7:0] seq [3] = '{8'h8A, 8'h20, 8'h8B};
    w0 = we_log.size(); r0 = re_log.size();
    i2c_start();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) i2c_rstart();
      send_byte(seq[i], ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_ack[%0d] got %b want 1", i, ack); end
    end
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop(); q_wait();
    checks++; if (d0 !== 8'h85) begin errors++; $display("FAIL read_byte0 got %h want 85", d0); end
    checks++; if (d1 !== 8'h84) begin errors++; $display("FAIL read_byte1 got %h want 84", d1); end
    checks++;
    if (re_log.size() - r0 != 2) begin errors++; $display("FAIL read_re_count got %0d want 2", re_log.size() - r0); end
    else begin
      checks++; if (re_log[r0] !== 8'h20 || re_log[r0+1] !== 8'h21) begin errors++; $display("FAIL read_re_addr got %h %h want 20 21", re_log[r0], re_log[r0+1]); end
    end
    checks++; if (we_log.size() != w0) begin errors++; $display("FAIL read_no_we got %0d want 0", we_log.size() - w0); end
    checks++; if (mem_addr !== 8'h21) begin errors++; $display("FAIL read_final_addr got %h want 21", mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle got %b want 0", busy); end
  endtask

  task automatic test_nomatch();
    logic ack; logic [7:0] d; int w0, r0, o0;
    w0 = we_log.size(); r0 = re_log.size(); o0 = oe_cnt;
    i2c_start();
    send_byte(8'h8C, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL nomatch_ack got %b want 0", ack); end
    send_byte(8'h10, ack);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nomatch_wait_stop got busy=%b want 1", busy); end
    i2c_stop(); q_wait();
    checks++; if (oe_cnt != o0) begin errors++; $display("FAIL nomatch_sda_oe got %0d drive cycles want 0", oe_cnt - o0); end
    checks++; if (we_log.size() != w0 || re_log.size() != r0) begin errors++; $display("FAIL nomatch_strobes got we=%0d re=%0d want 0 0", we_log.size() - w0, re_log.size() - r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nomatch_idle got %b want 0", busy); end
    // Current-address read afterwards uses the retained pointer 0x21.
    i2c_start();
    send_byte(8'h8B, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL cur_read_ack got %b want 1", ack); end
    read_byte(1'b1, d);
    i2c_stop(); q_wait();
    checks++; if (d !== 8'h84) begin errors++; $display("FAIL cur_read_data got %h want 84", d); end
    checks++; if (re_log.size() != r0 + 1 || re_log[re_log.size()-1] !== 8'h21) begin errors++; $display("FAIL cur_read_addr got n=%0d want 1 at 21", re_log.size() - r0); end
  endtask

  task automatic test_wrap();
    logic ack; logic [7:0] d0, d1; int w0, r0;
    logic [7:0] seq [4] = '{8'h8A, 8'hFF, 8'h11, 8'h22};
    w0 = we_log.size(); r0 = re_log.size();
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i], ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wrap_ack[%0d] got %b want 1", i, ack); end
    end
    i2c_stop(); q_wait();
    checks++;
    if (we_log.size() - w0 != 2) begin errors++; $display("FAIL wrap_we_count got %0d want 2", we_log.size() - w0); end
    else begin
      checks++; if (we_log[w0] !== 16'hFF11 || we_log[w0+1] !== 16'h0022) begin errors++; $display("FAIL wrap_we got %h %h want ff11 0022", we_log[w0], we_log[w0+1]); end
    end
    checks++; if (mem_addr !== 8'h01) begin errors++; $display("FAIL wrap_final_addr got %h want 01", mem_addr); end
    // Read back across the wrap.
    i2c_start(); send_byte(8'h8A, ack); send_byte(8'hFF, ack);
    i2c_rstart(); send_byte(8'h8B, ack);
    read_byte(1'b0, d0); read_byte(1'b1, d1);
    i2c_stop(); q_wait();
    checks++; if (d0 !== 8'h11 || d1 !== 8'h22) begin errors++; $display("FAIL wrap_readback got %h %h want 11 22", d0, d1); end
    checks++; if (re_log.size() != r0 + 2 || re_log[r0+1] !== 8'h00) begin errors++; $display("FAIL wrap_read_addr got n=%0d want 2 ending 00", re_log.size() - r0); end
  endtask

  task automatic test_reset_midwrite();
    logic ack; int w0;
    w0 = we_log.size();
    i2c_start(); send_byte(8'h8A, ack); send_byte(8'h40, ack);
    clock_bit(1'b1); clock_bit(1'b0); clock_bit(1'b0);
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_oe_busy got %b %b want 0 0", sda_oe, busy); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL midrst_addr got %h want 00", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL midrst_wdata got %h want 00", mem_wdata); end
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL midrst_strobes got %b %b want 0 0", mem_we, mem_re); end
    @(posedge clk); #1 rst_n = 1'b1;
    q_wait(); scl_m = 1'b0; q_wait();
    clock_bit(1'b0); clock_bit(1'b1); clock_bit(1'b1); clock_bit(1'b0);
    get_ack(ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL midrst_ignored_ack got %b want 0", ack); end
    i2c_stop(); q_wait();
    checks++; if (we_log.size() != w0) begin errors++; $display("FAIL midrst_no_we got %0d want 0", we_log.size() - w0); end
    i2c_start(); send_byte(8'h8A, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL post_rst_ack got %b want 1", ack); end
    send_byte(8'h55, ack); send_byte(8'h66, ack);
    i2c_stop(); q_wait();
    checks++; if (we_log.size() != w0 + 1 || we_log[we_log.size()-1] !== 16'h5566) begin errors++; $display("FAIL post_rst_write got n=%0d want 1 of 5566", we_log.size() - w0); end
    checks++; if (mem_addr !== 8'h56) begin errors++; $display("FAIL post_rst_addr got %h want 56", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_wrap();
    test_reset_midwrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_eeprom_slave_ctrl.md
I2C_EEPROM_SLAVE_CTRL -- requirements
Module: i2c_eeprom_slave_ctrl

Interface
REQ-001 SHALL have parameter DEV_TYPE, default 4'b1000: upper four bits of the 7-bit device address.
REQ-002 SHALL have parameter MIN_LOW, default 4: minimum scl low time in clk cycles that the block supports.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous to clk, active-low.
REQ-005 SHALL have port scl, input, 1 bit: I2C clock, asynchronous to clk.
REQ-006 SHALL have port sda, input, 1 bit: I2C data as read from the pad, asynchronous to clk.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 = pull the sda pad low; 0 = release it.
REQ-008 SHALL have ports a2, a1, a0, input, 1 bit each: device-select straps.
REQ-009 SHALL have port mem_addr, output, 8 bits: byte pointer into the memory array.
REQ-010 SHALL have port mem_wdata, output, 8 bits: write data.
REQ-011 SHALL have port mem_we, output, 1 bit: one-clk write strobe.
REQ-012 SHALL have port mem_re, output, 1 bit: one-clk read strobe.
REQ-013 SHALL have port mem_rdata, input, 8 bits: read data, valid on the clk after mem_re.
REQ-014 SHALL have port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-015 SHALL pass scl and sda each through a 2-flop synchronizer, then detect edges on the synchronized copies; all timing below refers to the synchronized signals.
REQ-016 SHALL detect START as an sda fall while scl is high, and STOP as an sda rise while scl is high.
REQ-017 SHALL sample sda on scl rising edges and change sda_oe only on scl falling edges.
REQ-018 SHALL use these states: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WA_ACK, WR_DATA, WD_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
REQ-019 SHALL use a 3-bit bit counter, cleared on START and at each byte boundary, receiving MSB first.
REQ-020 On any START, in any state (including a repeated START), SHALL go to DEV_ADDR, clear the bit counter, and set sda_oe=0 on the same clk.
REQ-021 On STOP, in any state, SHALL go to IDLE and set sda_oe=0.
REQ-022 On the 8th rising edge in DEV_ADDR, SHALL compare byte[7:1] with {DEV_TYPE,a2,a1,a0}; on match go to DEV_ACK, on mismatch go to WAIT_STOP and never drive sda.
REQ-023 In each ACK state, SHALL drive sda_oe=1 from the scl falling edge after the 8th bit to the next scl falling edge.
REQ-024 After DEV_ACK: if rw=0, SHALL go to WORD_ADDR; if rw=1, SHALL go to RD_LOAD.
REQ-025 After WORD_ADDR's 8th bit, SHALL load mem_addr with the received byte, then go WA_ACK -> WR_DATA.
REQ-026 On the 8th bit of WR_DATA, SHALL pulse mem_we for exactly one clk with mem_wdata=byte at the current mem_addr, then go to WD_ACK.
REQ-027 SHALL increment mem_addr on the clk after mem_we; 8'hFF SHALL wrap to 8'h00.
REQ-028 In RD_LOAD, SHALL pulse mem_re for one clk and capture mem_rdata on the next clk into the transmit shift register, completing before the scl falling edge that ends DEV_ACK or RD_ACK.
REQ-029 In RD_DATA, on each scl falling edge, SHALL drive sda_oe = ~shift_msb; after 8 bits it SHALL release sda and go to RD_ACK.
REQ-030 In RD_ACK, SHALL sample the master bit: 0 (ACK) -> increment mem_addr (with wrap) and go to RD_LOAD; 1 (NACK) -> go to WAIT_STOP.
REQ-031 A master write followed by a read without a word address (current-address read) SHALL use the retained mem_addr.
REQ-032 SHALL retain mem_addr across STOP; only reset or WORD_ADDR changes it apart from increments.
REQ-033 If START and STOP are detected on the same clk (not legal I2C), START SHALL take priority.

Reset
REQ-034 On the first clk edge with rst_n=0, SHALL set state=IDLE, sda_oe=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, bit counter=0, and both synchronizers to 1.
REQ-035 Reset mid-transfer SHALL abort the transfer with no mem_we or mem_re pulse; after release the block SHALL ignore the bus until the next START.

Verification
REQ-036 Straps a2..a0=3'b101; send START, 0x8A, 0x10, 0x5A, 0xC3, STOP -> ACK on every byte; mem_we at addr 0x10 data 0x5A, then at 0x11 data 0xC3; final mem_addr=0x12.
REQ-037 Send START, 0x8A, 0x20, repeated START, 0x8B, read two bytes with ACK then NACK, STOP -> mem_re at 0x20 and 0x21; sda carries memory bytes [0x20] then [0x21].
REQ-038 Straps 3'b101; send START, 0x8C -> no ACK (sda_oe stays 0), WAIT_STOP, no memory strobes; a following valid transaction works.
REQ-039 Write word address 0xFF, then data 0x11, 0x22 -> writes at 0xFF then 0x00 (wrap).
REQ-040 Assert rst_n=0 during the 4th data bit of a write -> outputs reach reset values after one clk; no mem_we; the next START is accepted normally.
